// File: rtl/bus_arbiter8.sv
// rtl/bus_arbiter8.sv - 8-way round-robin bus arbiter with registered one-hot grant.
// Optional burst lock (consecutive beats per grant) enabled by macro BURST_LOCK_EN.
module bus_arbiter8 #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] in,
    input  logic               out_ready,
    output logic [7:0]         gnt,
    output logic [7:0]         ack,
    output logic [2:0]         sel,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_check
        $error("bus_arbiter8: MAX_BURST must be in 1..15");
    end

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [2:0] sel_q;
    logic [7:0] gnt_q;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       transfer;
    logic       req_sel;

`ifdef BURST_LOCK_EN
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    logic [3:0] cnt_q;
`endif

    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        pick = ptr_q;
        idx  = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr_q + 3'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign req_sel   = req[sel_q];
    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req_sel;
    assign transfer  = out_valid & out_ready;
    assign ack       = transfer ? gnt_q : 8'h00;
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out       = busy ? in[32'(sel_q)*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
`ifdef BURST_LOCK_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q   <= pick;
                        gnt_q   <= 8'b1 << pick;
                        state_q <= GRANT;
`ifdef BURST_LOCK_EN
                        cnt_q   <= 4'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!req_sel) begin
                        ptr_q   <= sel_q + 3'd1;
                        gnt_q   <= 8'h00;
                        state_q <= IDLE;
                    end else if (out_ready) begin
`ifdef BURST_LOCK_EN
                        if (cnt_q < BURST_LAST) begin
                            cnt_q <= cnt_q + 4'd1;
                        end else begin
                            ptr_q   <= sel_q + 3'd1;
                            gnt_q   <= 8'h00;
                            state_q <= IDLE;
                        end
`else
                        ptr_q   <= sel_q + 3'd1;
                        gnt_q   <= 8'h00;
                        state_q <= IDLE;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 16, setting the data width of each requester and of out.
REQ-002 The block SHALL have a parameter MAX_BURST, default 4, setting the maximum consecutive beats per grant; legal range 1..15; it is used only with BURST_LOCK_EN.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 8, one request bit per requester; bit i is requester i.
REQ-006 The block SHALL have port in, input, 8*WIDTH, packed requester data; requester i occupies in[i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port out_ready, input, 1, downstream ready.
REQ-008 The block SHALL have port gnt, output, 8, one-hot grant, or all zero.
REQ-009 The block SHALL have port ack, output, 8, one-hot single-cycle transfer-complete pulse to the granted requester.
REQ-010 The block SHALL have port sel, output, 3, binary index of the current or last grant.
REQ-011 The block SHALL have port out, output, WIDTH, data of the granted requester.
REQ-012 The block SHALL have port out_valid, output, 1, out holds a valid beat.
REQ-013 The block SHALL have port busy, output, 1, high when the FSM is in GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE, if req is nonzero, the block SHALL pick the first set bit at or after index ptr, wrapping 7->0; at the next edge it SHALL load sel, set gnt to one-hot(sel) and enter GRANT.
REQ-016 Grant latency SHALL be 1 cycle, from req sampled in IDLE to gnt/out_valid high.
REQ-017 In GRANT, out SHALL equal in[sel*WIDTH +: WIDTH] combinationally, and out_valid SHALL equal req[sel].
REQ-018 In IDLE, out_valid and gnt SHALL be 0, and out SHALL be 0.
REQ-019 A transfer SHALL occur in any GRANT cycle with out_valid and out_ready both high; ack[sel] SHALL pulse high combinationally in that cycle only.
REQ-020 On a transfer with burst continuation not taken (REQ-030), the block SHALL set ptr to sel+1 mod 8, clear gnt and return to IDLE; this leaves one idle cycle between grants.
REQ-021 If req[sel] drops in GRANT before a transfer (abandon), the block SHALL produce no ack, set ptr to sel+1 mod 8 and return to IDLE at the next edge.
REQ-022 out_ready held low in GRANT SHALL keep the grant, sel and out_valid stable indefinitely; there is no timeout.
REQ-023 Requests arriving in GRANT SHALL be ignored until IDLE; requests arriving simultaneously SHALL be resolved by the round-robin rule only.
REQ-024 A single persistent requester SHALL be re-granted after each idle cycle, because the wrap search reaches it.
REQ-025 sel SHALL retain its last value in IDLE.

Reset
REQ-026 On reset_n low, asynchronously: state=IDLE, ptr=0, sel=0, gnt=0, ack=0, out_valid=0, out=0, busy=0, and the beat count=0.
REQ-027 Reset asserted mid-GRANT SHALL abort the transfer with no ack; after deassertion the block SHALL resume from IDLE with ptr=0 at the first rising edge.

Configuration
REQ-028 The feature SHALL be controlled by macro BURST_LOCK_EN.
REQ-029 Without BURST_LOCK_EN, every transfer SHALL end the grant as in REQ-020, and no beat counter SHALL exist.
REQ-030 With BURST_LOCK_EN, on a transfer where req[sel] is high in the same cycle and beat count < MAX_BURST-1, the block SHALL stay in GRANT, increment the count and keep sel; otherwise it SHALL follow REQ-020.
REQ-031 With BURST_LOCK_EN, the beat count SHALL clear on every entry to GRANT.

Verification
REQ-032 Reset then req=8'h00 for 10 cycles -> gnt=0, out_valid=0, busy=0 throughout.
REQ-033 req=8'h81, out_ready=1, held -> grants alternate 0,7,0,7 with one idle cycle between grants; each ack is a 1-cycle pulse.
REQ-034 req=8'h04 with in slice 2=16'hBEEF, out_ready=0 for 5 cycles then 1 -> out=16'hBEEF and out_valid=1 stable for 5 cycles; ack[2] in cycle 6.
REQ-035 Grant to requester 3, then req[3] dropped before out_ready -> no ack; next grant goes to the next requester at index >=4.
REQ-036 BURST_LOCK_EN, MAX_BURST=4, req=8'h03, out_ready=1 -> 4 consecutive acks to requester 0, idle cycle, then 4 to requester 1; without the macro the grants alternate every beat.
REQ-037 reset_n pulsed low mid-GRANT with sel=5 -> outputs 0 immediately with no ack; the first grant after reset is the lowest set req bit.
